// File: rtl/snax_alu_result_collector.sv
// Collects 2*DataWidth results from the ALU PE, packs PackNum of them per wide
// beat, queues beats in a small FIFO and pulses done after a programmed count.
module snax_alu_result_collector #(
  parameter int DataWidth = 64,
  parameter int PackNum   = 4,
  parameter int FifoDepth = 2,
  parameter int CntWidth  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [CntWidth-1:0]              num_results_i,
  input  logic [2*DataWidth-1:0]           c_i,
  input  logic                             c_valid_i,
  output logic                             c_ready_o,
  output logic                             acc_ready_o,
  output logic [PackNum*2*DataWidth-1:0]   out_data_o,
  output logic [PackNum-1:0]               out_strb_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int RW   = 2 * DataWidth;
  localparam int BW   = PackNum * RW;
  localparam int IdxW = (PackNum > 1) ? $clog2(PackNum) : 1;
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CW   = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [CntWidth-1:0]          r_remaining;
  logic [IdxW-1:0]              r_idx;
  logic [PackNum-1:0][RW-1:0]   r_pack;
  logic                         r_done;

  logic [BW-1:0]                r_mem_data [FifoDepth];
  logic [PackNum-1:0]           r_mem_strb [FifoDepth];
  logic [PtrW-1:0]              r_wr_ptr;
  logic [PtrW-1:0]              r_rd_ptr;
  logic [CW-1:0]                r_count;

  logic                         w_c_ready;
  logic                         w_busy;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_hs;
  logic                         w_last;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_zero_job;
  logic                         w_drain_done;
  logic [BW-1:0]                w_beat_data;
  logic [PackNum-1:0]           w_beat_strb;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_full       = (r_count == CW'(FifoDepth));
  assign w_empty      = (r_count == '0);
  assign w_hs         = c_valid_i && w_c_ready;
  assign w_last       = (r_remaining == CntWidth'(1));
  assign w_push       = w_hs && ((r_idx == IdxW'(PackNum - 1)) || w_last);
  assign w_pop        = !w_empty && out_ready_i;
  assign w_zero_job   = (r_state == IDLE) && start_i && (num_results_i == '0);
  assign w_drain_done = (r_state == DRAIN) && w_empty;

  // Outgoing beat = pack register with the in-flight result dropped into lane idx.
  for (genvar gi = 0; gi < PackNum; gi++) begin : g_lane
    assign w_beat_data[gi*RW +: RW] = (r_idx == IdxW'(gi)) ? c_i : r_pack[gi];
    assign w_beat_strb[gi]          = (IdxW'(gi) <= r_idx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i && (num_results_i != '0)) w_state_next = COLLECT;
      COLLECT: if (w_hs && w_last)                   w_state_next = DRAIN;
      DRAIN:   if (w_empty)                          w_state_next = IDLE;
      default:                                       w_state_next = IDLE;
    endcase
  end

  // Ready depends only on the pre-pop fill level, never on out_ready_i.
  always_comb begin
    w_c_ready = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      COLLECT: begin
        w_c_ready = !w_full;
        w_busy    = 1'b1;
      end
      DRAIN:   w_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_remaining <= '0;
      r_idx       <= '0;
      r_pack      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_zero_job || w_drain_done;
      if ((r_state == IDLE) && start_i) r_remaining <= num_results_i;
      if (w_hs) begin
        r_remaining <= r_remaining - CntWidth'(1);
        if (w_push) begin
          r_idx  <= '0;
          r_pack <= '0;
        end else begin
          r_idx         <= r_idx + IdxW'(1);
          r_pack[r_idx] <= c_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_beat_data;
      r_mem_strb[r_wr_ptr] <= w_beat_strb;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign c_ready_o   = w_c_ready;
  assign acc_ready_o = w_c_ready;
  assign busy_o      = w_busy;
  assign done_o      = r_done;
  assign out_valid_o = !w_empty;
  assign out_data_o  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign out_strb_o  = w_empty ? '0 : r_mem_strb[r_rd_ptr];

endmodule
